// File: rtl/rv32_exec_sequencer_if.sv
// Fetch-to-sequencer instruction handshake.
// Fetch drives the master side; the sequencer is the slave.
interface rv32_exec_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/rv32_exec_sequencer.sv
// Multi-cycle RV32I sequencer: decode, one-cycle ALU strobe,
// latency wait, then writeback / PC-update commands.
module rv32_exec_sequencer #(
  parameter int ALU_LATENCY  = 1,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rv32_exec_sequencer_if.slave    fetch,
  output logic [4:0]              rs1_addr,
  output logic [4:0]              rs2_addr,
  output logic [31:0]             imm,
  output logic                    lup,
  output logic                    ub,
  output logic                    cb,
  output logic                    mem,
  output logic                    alu_imm,
  output logic                    alu_reg,
  output logic                    iop,
  output logic                    fc,
  output logic [2:0]              finite_control_sig,
  output logic [4:0]              rd_addr,
  output logic                    rd_we,
  output logic                    pc_we,
  output logic                    pc_inc,
  output logic                    retire,
  output logic                    illegal,
  output logic [RETIRE_CNT_W-1:0] retire_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_WAIT, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_LUP, C_UB, C_CB, C_IMM, C_REG
  } cls_t;

  localparam logic [1:0] WAIT_INIT = 2'(ALU_LATENCY - 2);

  state_t state_q, state_d;
  cls_t   cls_q, dec_cls;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, imm_q, dec_imm;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [2:0]  fcs_q, dec_fcs;
  logic        iop_q, dec_iop, dec_ok;
  logic [RETIRE_CNT_W-1:0] rcnt_q;

  logic [4:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       quad;

  assign op   = instr_q[6:2];
  assign f3   = instr_q[14:12];
  assign f7   = instr_q[31:25];
  assign quad = instr_q[1:0] == 2'b11;

  always_comb begin
    dec_ok  = 1'b0;
    dec_cls = C_NONE;
    dec_imm = '0;
    dec_iop = 1'b0;
    dec_fcs = f3;
    unique case (1'b1)
      op == 5'b00100: begin
        dec_cls = C_IMM;
        dec_imm = {{20{instr_q[31]}}, instr_q[31:20]};
        dec_iop = (f3 == 3'b101) && instr_q[30];
        if (f3 == 3'b001)
          dec_ok = f7 == 7'h00;
        else if (f3 == 3'b101)
          dec_ok = (f7 == 7'h00) || (f7 == 7'h20);
        else
          dec_ok = 1'b1;
      end
      op == 5'b01100: begin
        dec_cls = C_REG;
        dec_iop = instr_q[30];
        dec_ok  = (f7 == 7'h00) ||
                  ((f7 == 7'h20) &&
                   ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      op == 5'b11000: begin
        dec_cls = C_CB;
        dec_imm = {{20{instr_q[31]}}, instr_q[7],
                   instr_q[30:25], instr_q[11:8], 1'b0};
        dec_ok  = (f3 != 3'b010) && (f3 != 3'b011);
      end
      op == 5'b11011: begin
        dec_cls = C_UB;
        dec_fcs = 3'b010;
        dec_imm = {{12{instr_q[31]}}, instr_q[19:12],
                   instr_q[20], instr_q[30:21], 1'b0};
        dec_ok  = 1'b1;
      end
      op == 5'b11001: begin
        dec_cls = C_UB;
        dec_fcs = 3'b011;
        dec_imm = {{20{instr_q[31]}}, instr_q[31:20]};
        dec_ok  = f3 == 3'b000;
      end
      op == 5'b01101: begin
        dec_cls = C_LUP;
        dec_fcs = 3'b000;
        dec_iop = 1'b1;
        dec_imm = {12'b0, instr_q[31:12]};
        dec_ok  = 1'b1;
      end
      op == 5'b00101: begin
        dec_cls = C_LUP;
        dec_fcs = 3'b000;
        dec_imm = {instr_q[31:12], 12'b0};
        dec_ok  = 1'b1;
      end
      default: ;
    endcase
    dec_ok = dec_ok && quad;
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    fetch.instr_ready = 1'b0;
    lup     = 1'b0;
    ub      = 1'b0;
    cb      = 1'b0;
    alu_imm = 1'b0;
    alu_reg = 1'b0;
    rd_we   = 1'b0;
    pc_we   = 1'b0;
    pc_inc  = 1'b0;
    retire  = 1'b0;
    illegal = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        fetch.instr_ready = 1'b1;
        if (fetch.instr_valid)
          state_d = S_DECODE;
      end
      S_DECODE: state_d = dec_ok ? S_EXEC : S_TRAP;
      S_EXEC: begin
        lup     = cls_q == C_LUP;
        ub      = cls_q == C_UB;
        cb      = cls_q == C_CB;
        alu_imm = cls_q == C_IMM;
        alu_reg = cls_q == C_REG;
        cnt_d   = WAIT_INIT;
        state_d = (ALU_LATENCY == 1) ? S_WB : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0)
          state_d = S_WB;
        else
          cnt_d = cnt_q - 2'd1;
      end
      S_WB: begin
        rd_we   = (cls_q != C_CB) && (rd_q != 5'd0);
        pc_we   = (cls_q == C_UB) || (cls_q == C_CB);
        pc_inc  = (cls_q == C_IMM) || (cls_q == C_REG) ||
                  (cls_q == C_LUP);
        retire  = 1'b1;
        state_d = S_IDLE;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      cls_q   <= C_NONE;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      fcs_q   <= '0;
      iop_q   <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && fetch.instr_valid)
        instr_q <= fetch.instr;
      // Decode results stay frozen until the next DECODE.
      if (state_q == S_DECODE) begin
        cls_q <= dec_cls;
        imm_q <= dec_imm;
        iop_q <= dec_iop;
        fcs_q <= dec_fcs;
        rs1_q <= instr_q[19:15];
        rs2_q <= instr_q[24:20];
        rd_q  <= instr_q[11:7];
      end
      if (state_q == S_WB)
        rcnt_q <= rcnt_q + 1'b1;
    end
  end

  assign rs1_addr           = rs1_q;
  assign rs2_addr           = rs2_q;
  assign rd_addr            = rd_q;
  assign imm                = imm_q;
  assign iop                = iop_q;
  assign finite_control_sig = fcs_q;
  assign mem                = 1'b0;
  assign fc                 = 1'b0;
  assign retire_count       = rcnt_q;

endmodule

// File: tb/tb_rv32_exec_sequencer.sv
// Bench for rv32_exec_sequencer: two instances (latency 1 and 3)
// checked every cycle against a timeline model of the decode rules.
module tb_rv32_exec_sequencer;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        lup;
    logic        ub;
    logic        cb;
    logic        mem;
    logic        ai;
    logic        ar;
    logic        iop;
    logic        fc;
    logic [2:0]  fcs;
    logic        rd_we;
    logic        pc_we;
    logic        pc_inc;
    logic        retire;
    logic        illegal;
    logic        ready;
    logic [31:0] rc;
  } obs_t;

  typedef struct packed {
    logic        ok;
    logic [2:0]  kind;
    logic [31:0] imm;
    logic        iop;
    logic [2:0]  fcs;
  } dec_t;

  localparam logic [2:0] K_LUP = 3'd1;
  localparam logic [2:0] K_UB  = 3'd2;
  localparam logic [2:0] K_CB  = 3'd3;
  localparam logic [2:0] K_IMM = 3'd4;
  localparam logic [2:0] K_REG = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tb_valid = 1'b0;
  logic [31:0] tb_instr = '0;
  obs_t        o [2];

  int n_chk  = 0;
  int n_pass = 0;
  bit run    = 1'b0;

  int          age [2] = '{0, 0};
  logic [31:0] cur [2] = '{32'h0, 32'h0};
  logic [31:0] rcm [2] = '{32'h0, 32'h0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rv32_exec_sequencer_if bus ();
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, rc;
    logic        lup, ub, cb, mem, ai, ar, iop, fc;
    logic [2:0]  fcs;
    logic        rd_we, pc_we, pc_inc, retire, illegal;

    assign bus.instr_valid = tb_valid;
    assign bus.instr       = tb_instr;

    rv32_exec_sequencer #(
      .ALU_LATENCY  (g == 0 ? 1 : 3),
      .RETIRE_CNT_W (32)
    ) u_dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .fetch              (bus),
      .rs1_addr           (rs1),
      .rs2_addr           (rs2),
      .imm                (imm),
      .lup                (lup),
      .ub                 (ub),
      .cb                 (cb),
      .mem                (mem),
      .alu_imm            (ai),
      .alu_reg            (ar),
      .iop                (iop),
      .fc                 (fc),
      .finite_control_sig (fcs),
      .rd_addr            (rd),
      .rd_we              (rd_we),
      .pc_we              (pc_we),
      .pc_inc             (pc_inc),
      .retire             (retire),
      .illegal            (illegal),
      .retire_count       (rc)
    );

    assign o[g] = '{rs1: rs1, rs2: rs2, rd: rd, imm: imm,
                    lup: lup, ub: ub, cb: cb, mem: mem,
                    ai: ai, ar: ar, iop: iop, fc: fc, fcs: fcs,
                    rd_we: rd_we, pc_we: pc_we, pc_inc: pc_inc,
                    retire: retire, illegal: illegal,
                    ready: bus.instr_ready, rc: rc};
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Decode straight from the ISA field definitions.
  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    d  = '0;
    d.fcs = f3;
    if (w[1:0] == 2'b11) begin
      case (w[6:2])
        5'b00100: begin
          d.kind = K_IMM;
          d.imm  = $signed(w) >>> 20;
          d.iop  = (f3 == 3'd5) && w[30];
          d.ok   = (f3 == 3'd1) ? (f7 == 7'd0) :
                   (f3 == 3'd5) ? (f7 == 7'd0 || f7 == 7'd32) : 1'b1;
        end
        5'b01100: begin
          d.kind = K_REG;
          d.iop  = w[30];
          d.ok   = (f7 == 7'd0) ||
                   (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5));
        end
        5'b11000: begin
          d.kind = K_CB;
          d.imm  = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
          d.ok   = (f3 != 3'd2) && (f3 != 3'd3);
        end
        5'b11011: begin
          d.kind = K_UB;
          d.fcs  = 3'd2;
          d.imm  = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
          d.ok   = 1'b1;
        end
        5'b11001: begin
          d.kind = K_UB;
          d.fcs  = 3'd3;
          d.imm  = $signed(w) >>> 20;
          d.ok   = f3 == 3'd0;
        end
        5'b01101: begin
          d.kind = K_LUP;
          d.fcs  = 3'd0;
          d.iop  = 1'b1;
          d.imm  = w >> 12;
          d.ok   = 1'b1;
        end
        5'b00101: begin
          d.kind = K_LUP;
          d.fcs  = 3'd0;
          d.imm  = w & 32'hFFFF_F000;
          d.ok   = 1'b1;
        end
        default: d.ok = 1'b0;
      endcase
    end
    return d;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  ops [7] = '{5'b00100, 5'b01100, 5'b11000,
                             5'b11011, 5'b11001, 5'b01101, 5'b00101};
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 7);
    if (r < 6) begin
      w[6:0] = {ops[$urandom_range(0, 6)], 2'b11};
      if ($urandom_range(0, 1) == 1)
        w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
    end
    return w;
  endfunction

  task automatic cmp(input int k, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL dut%0d %s actual=%h required=%h t=%0t",
               k, name, act, exp, $time);
  endtask

  // Timeline model: age counts cycles since the accept edge.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        age[k] <= 0;
        rcm[k] <= '0;
      end else if (age[k] == 0) begin
        if (tb_valid) begin
          age[k] <= 1;
          cur[k] <= tb_instr;
        end
      end else begin
        dec_t d;
        d = ref_dec(cur[k]);
        if (age[k] == (d.ok ? 2 + lat(k) : 2)) begin
          age[k] <= 0;
          if (d.ok)
            rcm[k] <= rcm[k] + 32'd1;
        end else begin
          age[k] <= age[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        dec_t d;
        int   a;
        bit   ex, wb;
        d  = ref_dec(cur[k]);
        a  = age[k];
        ex = (a == 2) && d.ok;
        wb = d.ok && (a == 2 + lat(k));
        cmp(k, "ready", 32'(o[k].ready), 32'(a == 0));
        cmp(k, "lup", 32'(o[k].lup), 32'(ex && d.kind == K_LUP));
        cmp(k, "ub", 32'(o[k].ub), 32'(ex && d.kind == K_UB));
        cmp(k, "cb", 32'(o[k].cb), 32'(ex && d.kind == K_CB));
        cmp(k, "alu_imm", 32'(o[k].ai), 32'(ex && d.kind == K_IMM));
        cmp(k, "alu_reg", 32'(o[k].ar), 32'(ex && d.kind == K_REG));
        cmp(k, "mem", 32'(o[k].mem), 32'd0);
        cmp(k, "fc", 32'(o[k].fc), 32'd0);
        cmp(k, "illegal", 32'(o[k].illegal),
            32'((a == 2) && !d.ok));
        cmp(k, "rd_we", 32'(o[k].rd_we),
            32'(wb && d.kind != K_CB && cur[k][11:7] != 5'd0));
        cmp(k, "pc_we", 32'(o[k].pc_we),
            32'(wb && (d.kind == K_UB || d.kind == K_CB)));
        cmp(k, "pc_inc", 32'(o[k].pc_inc),
            32'(wb && (d.kind == K_IMM || d.kind == K_REG ||
                       d.kind == K_LUP)));
        cmp(k, "retire", 32'(o[k].retire), 32'(wb));
        cmp(k, "retire_count", o[k].rc, rcm[k]);
        if (a >= 2) begin
          cmp(k, "rs1", 32'(o[k].rs1), 32'(cur[k][19:15]));
          cmp(k, "rs2", 32'(o[k].rs2), 32'(cur[k][24:20]));
          cmp(k, "rd", 32'(o[k].rd), 32'(cur[k][11:7]));
        end
        if (a >= 2 && d.ok) begin
          cmp(k, "imm", o[k].imm, d.imm);
          cmp(k, "iop", 32'(o[k].iop), 32'(d.iop));
          cmp(k, "fcs", 32'(o[k].fcs), 32'(d.fcs));
        end
      end
    end
  end

  // Returns at the negedge of the DECODE cycle of both instances.
  task automatic send(input logic [31:0] w);
    int n;
    tb_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(o[0].ready && o[1].ready) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      n_chk++;
      $display("FAIL send_timeout actual=busy required=ready t=%0t",
               $time);
    end
    tb_valid = 1'b1;
    tb_instr = w;
    @(negedge clk);
    tb_valid = 1'b0;
    tb_instr = $urandom;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cmp(0, "rst_ready", 32'(o[0].ready), 32'd1);
    cmp(1, "rst_ready", 32'(o[1].ready), 32'd1);
    cmp(0, "rst_rc", o[0].rc, 32'd0);
    run = 1'b1;

    send(32'hFFD08293);
    @(negedge clk);
    cmp(0, "addi_stb", 32'(o[0].ai), 32'd1);
    cmp(0, "addi_imm", o[0].imm, 32'hFFFF_FFFD);
    cmp(0, "addi_fcs", 32'(o[0].fcs), 32'd0);
    @(negedge clk);
    cmp(0, "addi_rdwe", 32'(o[0].rd_we), 32'd1);
    cmp(0, "addi_rd", 32'(o[0].rd), 32'd5);
    cmp(0, "addi_pcinc", 32'(o[0].pc_inc), 32'd1);
    cmp(0, "addi_rc0", o[0].rc, 32'd0);
    @(negedge clk);
    cmp(0, "addi_rc1", o[0].rc, 32'd1);

    send(32'h405251B3);
    @(negedge clk);
    cmp(0, "sra_stb", 32'(o[0].ar), 32'd1);
    cmp(0, "sra_fcs", 32'(o[0].fcs), 32'd5);
    cmp(0, "sra_iop", 32'(o[0].iop), 32'd1);

    send(32'h025251B3);
    @(negedge clk);
    cmp(0, "bad_illegal", 32'(o[0].illegal), 32'd1);
    cmp(0, "bad_rdwe", 32'(o[0].rd_we), 32'd0);
    @(negedge clk);
    cmp(0, "bad_rc", o[0].rc, 32'd2);

    send(32'h00208863);
    @(negedge clk);
    cmp(0, "beq_cb", 32'(o[0].cb), 32'd1);
    cmp(0, "beq_imm", o[0].imm, 32'd16);
    @(negedge clk);
    cmp(0, "beq_pcwe", 32'(o[0].pc_we), 32'd1);
    cmp(0, "beq_rdwe", 32'(o[0].rd_we), 32'd0);

    send(32'h123453B7);
    @(negedge clk);
    cmp(0, "lui_imm", o[0].imm, 32'h0001_2345);
    cmp(0, "lui_iop", 32'(o[0].iop), 32'd1);
    send(32'h12345397);
    @(negedge clk);
    cmp(0, "auipc_imm", o[0].imm, 32'h1234_5000);
    cmp(0, "auipc_iop", 32'(o[0].iop), 32'd0);

    send(32'h008000EF);
    @(negedge clk);
    cmp(1, "jal_ub", 32'(o[1].ub), 32'd1);
    cmp(1, "jal_imm", o[1].imm, 32'd8);
    for (int i = 0; i < 2; i++) begin
      tb_valid = 1'b1;
      tb_instr = gen_instr();
      @(negedge clk);
      cmp(1, "jal_wait", 32'(o[1].retire), 32'd0);
    end
    tb_instr = gen_instr();
    @(negedge clk);
    cmp(1, "jal_pcwe", 32'(o[1].pc_we), 32'd1);
    cmp(1, "jal_rdwe", 32'(o[1].rd_we), 32'd1);
    tb_valid = 1'b0;

    send(32'h002080B3);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp(1, "arst_ready", 32'(o[1].ready), 32'd1);
    cmp(1, "arst_rc", o[1].rc, 32'd0);
    cmp(1, "arst_retire", 32'(o[1].retire), 32'd0);
    cmp(0, "arst_rc", o[0].rc, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    send(32'h00000033);
    @(negedge clk);
    @(negedge clk);
    cmp(0, "x0_retire", 32'(o[0].retire), 32'd1);
    cmp(0, "x0_rdwe", 32'(o[0].rd_we), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      tb_valid = ($urandom_range(0, 2) != 0);
      tb_instr = gen_instr();
    end
    tb_valid = 1'b0;
    repeat (10) @(negedge clk);
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
